// File: rtl/top4_pkg.sv
// rtl/top4_pkg.sv - shared types and constants for the top-4 sorter (TOP4_ABS_EN selects magnitude ranking)
package top4_pkg;

    localparam int DATA_W    = 16;
    localparam int IDX_W     = 6;
    localparam int CNT_W     = 7;
    localparam int FIRST_CNT = 6;
    localparam int LAST_CNT  = 69;
    localparam int K         = 4;

    typedef struct packed {
        logic                     valid;
        logic signed [DATA_W-1:0] value;
        logic [IDX_W-1:0]         index;
    } slot_t;

    localparam logic signed [DATA_W-1:0] VAL_EMPTY = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] VAL_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [IDX_W-1:0]         IDX_EMPTY = '1;
    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, value: VAL_EMPTY, index: IDX_EMPTY};

    // Ordering key; the magnitude variant saturates so the most-negative sample still ranks at the top.
    function automatic logic signed [DATA_W-1:0] rank_key(input logic signed [DATA_W-1:0] x);
`ifdef TOP4_ABS_EN
        if (x == VAL_EMPTY)
            return VAL_MAX;
        else if (x < 0)
            return -x;
        else
            return x;
`else
        return x;
`endif
    endfunction

endpackage

// File: rtl/top4_slot.sv
// rtl/top4_slot.sv - one entry of the running top-4 list (value, index, valid)
module top4_slot
    import top4_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  keep_new,
    input  logic  insert,
    input  logic  beat,
    input  logic  beat_up,
    input  slot_t new_entry,
    input  slot_t up_entry,
    output slot_t q
);

    // On clear the head slot may immediately take the first sample of the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SLOT_EMPTY;
        end else if (clear) begin
            q <= keep_new ? new_entry : SLOT_EMPTY;
        end else if (insert && beat_up) begin
            q <= up_entry;
        end else if (insert && beat) begin
            q <= new_entry;
        end
    end

endmodule

// File: rtl/top4_sorter.sv
// rtl/top4_sorter.sv - per-frame running top-4 list with registered result beat (TOP4_ABS_EN: rank by magnitude)
module top4_sorter
    import top4_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [CNT_W-1:0]     cnt,
    input  logic                 out_data_flag,
    output logic                 out_vld,
    output logic [K*DATA_W-1:0]  top_val,
    output logic [K*IDX_W-1:0]   top_idx,
    output logic [2:0]           top_cnt
);

    slot_t              slot_q [K];
    slot_t              up_q   [K];
    slot_t              new_entry;
    logic [K-1:0]       beat;
    logic [K-1:0]       beat_up;
    logic [K-1:0]       keep_new;
    logic               accept;
    logic               close;
    logic               flag_d;
    logic [K*DATA_W-1:0] snap_val;
    logic [K*IDX_W-1:0]  snap_idx;
    logic [2:0]          snap_cnt;

    assign accept = in_vld && (cnt >= CNT_W'(FIRST_CNT)) && (cnt <= CNT_W'(LAST_CNT));
    assign close  = out_data_flag && !flag_d;

    always_comb begin
        new_entry       = SLOT_EMPTY;
        new_entry.valid = 1'b1;
        new_entry.value = in_data;
        new_entry.index = IDX_W'(cnt - CNT_W'(FIRST_CNT));
    end

    // The list is kept sorted, so beat[] is a thermometer: the first set bit is the insertion point.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            beat[i] = !slot_q[i].valid ||
                      (rank_key(in_data) > rank_key(slot_q[i].value));
        end
    end

    assign beat_up  = {beat[K-2:0], 1'b0};
    assign keep_new = {{(K-1){1'b0}}, accept};

    always_comb begin
        up_q[0] = SLOT_EMPTY;
        for (int i = 1; i < K; i++) begin
            up_q[i] = slot_q[i-1];
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_slot
        top4_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (close),
            .keep_new  (keep_new[i]),
            .insert    (accept),
            .beat      (beat[i]),
            .beat_up   (beat_up[i]),
            .new_entry (new_entry),
            .up_entry  (up_q[i]),
            .q         (slot_q[i])
        );
    end

    always_comb begin
        snap_val = '0;
        snap_idx = '0;
        snap_cnt = '0;
        for (int i = 0; i < K; i++) begin
            snap_val[i*DATA_W +: DATA_W] = slot_q[i].value;
            snap_idx[i*IDX_W +: IDX_W]   = slot_q[i].index;
            snap_cnt                     = snap_cnt + 3'(slot_q[i].valid);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_d  <= 1'b0;
            out_vld <= 1'b0;
            top_val <= '0;
            top_idx <= '0;
            top_cnt <= '0;
        end else begin
            flag_d  <= out_data_flag;
            out_vld <= close;
            if (close) begin
                top_val <= snap_val;
                top_idx <= snap_idx;
                top_cnt <= snap_cnt;
            end
        end
    end

endmodule
